// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - round-robin arbiter sharing the register-file decode path
// between the operand read port and the integer/FP writeback ports.
module regfile_port_arbiter #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [31:0]       rd_instr,
    output logic              rd_ready,
    output logic              rd_done,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    output logic              wb_err,
    output logic [31:0]       rf_instruction,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr3,
    output logic [DATA_W-1:0] rf_data_in
);
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [1:0]        last;
    logic [2:0]        req;
    logic [2:0]        gnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_in_range;
    logic              rd_pend;

    assign req = {wb1_valid, wb0_valid, rd_valid};

    // Search starts one past the last winner; nobody is granted while in reset.
    always_comb begin
        gnt = 3'b000;
        if (!rst) begin
            case (last)
                2'd0: begin
                    if (req[1])      gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                2'd1: begin
                    if (req[2])      gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
                default: begin
                    if (req[0])      gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    assign rd_ready  = gnt[0];
    assign wb0_ready = gnt[1];
    assign wb1_ready = gnt[2];

    assign wr_addr     = gnt[2] ? wb1_addr : wb0_addr;
    assign wr_data     = gnt[2] ? wb1_data : wb0_data;
    assign wr_in_range = {1'b0, wr_addr} < REG_LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            last           <= 2'd2;
            rf_instruction <= '0;
            rf_we          <= 1'b0;
            rf_addr3       <= '0;
            rf_data_in     <= '0;
            rd_pend        <= 1'b0;
            rd_done        <= 1'b0;
            wb_err         <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            wb_err  <= 1'b0;
            rd_pend <= gnt[0];
            rd_done <= rd_pend;

            if (gnt[0])      last <= 2'd0;
            else if (gnt[1]) last <= 2'd1;
            else if (gnt[2]) last <= 2'd2;

            // rf_instruction only moves on a read so idle cycles keep re-reading rs/rt.
            if (gnt[0]) begin
                rf_instruction <= rd_instr;
            end else if (gnt[1] || gnt[2]) begin
                if (wr_in_range) begin
                    rf_we      <= 1'b1;
                    rf_addr3   <= wr_addr;
                    rf_data_in <= wr_data;
                end else begin
                    wb_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - self-checking bench for regfile_port_arbiter with a
// register-file stand-in and a behavioural arbitration/register model.
module tb_regfile_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_valid, rd_ready, rd_done;
    logic [31:0] rd_instr;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready, wb_err;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic [31:0] rf_instruction, rf_data_in;
    logic        rf_we;
    logic [4:0]  rf_addr3;

    logic [31:0] rf_mem [0:15];
    logic [31:0] dout1, dout2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_instr(rd_instr), .rd_ready(rd_ready), .rd_done(rd_done),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .wb_err(wb_err), .rf_instruction(rf_instruction), .rf_we(rf_we),
        .rf_addr3(rf_addr3), .rf_data_in(rf_data_in)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 14) return 32'h415e6666;
        if (i == 15) return 32'h4161999a;
        return 32'h3f80_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] mk_instr(int rs, int rt);
        return {6'd0, 5'(rs), 5'(rt), 16'h0};
    endfunction

    // Register file stand-in: a write cycle suppresses the read.
    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (rf_we) rf_mem[rf_addr3[3:0]] = rf_data_in;
            else begin
                dout1 = rf_mem[rf_instruction[24:21]];
                dout2 = rf_mem[rf_instruction[19:16]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_valid = 0; wb0_valid = 0; wb1_valid = 0;
        rd_instr = 0; wb0_addr = 0; wb0_data = 0; wb1_addr = 0; wb1_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        rd_valid = 1; wb0_valid = 1; wb1_valid = 1;
        tick(); tick();
        @(negedge clk);
        checks++; if ({wb1_ready, wb0_ready, rd_ready} !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", {wb1_ready, wb0_ready, rd_ready}); end
        checks++; if (rf_we !== 1'b0 || rf_addr3 !== 5'd0 || rf_data_in !== 32'd0) begin errors++; $display("FAIL reset_rf: we=%b addr3=%h data=%h expected 0/0/0", rf_we, rf_addr3, rf_data_in); end
        checks++; if (rf_instruction !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", rf_instruction); end
        checks++; if (rd_done !== 1'b0 || wb_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: rd_done=%b wb_err=%b expected 0/0", rd_done, wb_err); end
        idle_inputs();
        tick();
        rst = 0;
    endtask

    task automatic test_read_basic();
        do_reset();
        rd_valid = 1; rd_instr = mk_instr(14, 15);
        @(negedge clk);
        checks++; if ({wb1_ready, wb0_ready, rd_ready} !== 3'b001) begin errors++; $display("FAIL read_grant: got %b expected 001", {wb1_ready, wb0_ready, rd_ready}); end
        tick(); rd_valid = 0;
        @(negedge clk);
        checks++; if (rf_instruction !== mk_instr(14, 15) || rf_we !== 1'b0) begin errors++; $display("FAIL read_rf: instr=%h we=%b expected %h/0", rf_instruction, rf_we, mk_instr(14, 15)); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL read_done_early: got %b expected 0", rd_done); end
        tick();
        @(negedge clk);
        checks++; if (rd_done !== 1'b1) begin errors++; $display("FAIL read_done: got %b expected 1", rd_done); end
        checks++; if (dout1 !== 32'h415e6666 || dout2 !== 32'h4161999a) begin errors++; $display("FAIL read_data: got %h %h expected 415e6666 4161999a", dout1, dout2); end
        tick();
        @(negedge clk);
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL read_done_width: got %b expected 0", rd_done); end
    endtask

    task automatic test_write_then_read();
        do_reset();
        wb0_valid = 1; wb0_addr = 5'd3; wb0_data = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if ({wb1_ready, wb0_ready, rd_ready} !== 3'b010) begin errors++; $display("FAIL wr_grant: got %b expected 010", {wb1_ready, wb0_ready, rd_ready}); end
        tick(); wb0_valid = 0; rd_valid = 1; rd_instr = mk_instr(3, 3);
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_addr3 !== 5'd3 || rf_data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rf: we=%b addr3=%h data=%h expected 1/3/deadbeef", rf_we, rf_addr3, rf_data_in); end
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL wr_read_grant: got %b expected 1", rd_ready); end
        tick(); rd_valid = 0;
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wr_we_width: got %b expected 0", rf_we); end
        tick();
        @(negedge clk);
        checks++; if (rd_done !== 1'b1 || dout1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_readback: done=%b dout1=%h expected 1/deadbeef", rd_done, dout1); end
    endtask

    task automatic test_round_robin();
        do_reset();
        rd_valid = 1; rd_instr = mk_instr(1, 2);
        wb0_valid = 1; wb0_addr = 5'd1; wb0_data = 32'h1111_0001;
        wb1_valid = 1; wb1_addr = 5'd2; wb1_data = 32'h2222_0002;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if ({wb1_ready, wb0_ready, rd_ready} !== 3'(1 << (c % 3))) begin
                errors++; $display("FAIL rr_cycle%0d: got %b expected %b", c, {wb1_ready, wb0_ready, rd_ready}, 3'(1 << (c % 3)));
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_bad_addr();
        do_reset();
        wb1_valid = 1; wb1_addr = 5'd20; wb1_data = 32'h1234_5678;
        @(negedge clk);
        checks++; if (wb1_ready !== 1'b1) begin errors++; $display("FAIL bad_ready: got %b expected 1", wb1_ready); end
        tick(); wb1_valid = 0;
        @(negedge clk);
        checks++; if (wb_err !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL bad_err: wb_err=%b we=%b expected 1/0", wb_err, rf_we); end
        tick(); rd_valid = 1; rd_instr = mk_instr(4, 4);
        @(negedge clk);
        checks++; if (wb_err !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL bad_err_width: wb_err=%b we=%b expected 0/0", wb_err, rf_we); end
        tick(); rd_valid = 0;
        tick();
        @(negedge clk);
        checks++; if (rd_done !== 1'b1 || dout1 !== init_val(4)) begin errors++; $display("FAIL bad_r4: done=%b dout1=%h expected 1/%h", rd_done, dout1, init_val(4)); end
    endtask

    task automatic test_same_addr();
        do_reset();
        wb0_valid = 1; wb0_addr = 5'd5; wb0_data = 32'd1;
        wb1_valid = 1; wb1_addr = 5'd5; wb1_data = 32'd2;
        @(negedge clk);
        checks++; if ({wb1_ready, wb0_ready, rd_ready} !== 3'b010) begin errors++; $display("FAIL same_first: got %b expected 010", {wb1_ready, wb0_ready, rd_ready}); end
        tick(); wb0_valid = 0;
        @(negedge clk);
        checks++; if (wb1_ready !== 1'b1 || rf_data_in !== 32'd1) begin errors++; $display("FAIL same_second: ready=%b data=%h expected 1/1", wb1_ready, rf_data_in); end
        tick(); wb1_valid = 0; rd_valid = 1; rd_instr = mk_instr(5, 5);
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_data_in !== 32'd2) begin errors++; $display("FAIL same_wr2: we=%b data=%h expected 1/2", rf_we, rf_data_in); end
        tick(); rd_valid = 0;
        tick();
        @(negedge clk);
        checks++; if (rd_done !== 1'b1 || dout1 !== 32'd2) begin errors++; $display("FAIL same_read: done=%b dout1=%h expected 1/2", rd_done, dout1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rd_valid = 1; rd_instr = mk_instr(14, 14);
        @(negedge clk);
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL mid_grant: got %b expected 1", rd_ready); end
        tick(); rd_valid = 0; rst = 1;
        tick(); rst = 0;
        rd_valid = 1; wb0_valid = 1; wb0_addr = 5'd7; wb1_valid = 1; wb1_addr = 5'd8;
        @(negedge clk);
        checks++; if (rd_done !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL mid_cancel: done=%b we=%b expected 0/0", rd_done, rf_we); end
        checks++; if ({wb1_ready, wb0_ready, rd_ready} !== 3'b001) begin errors++; $display("FAIL mid_first: got %b expected 001", {wb1_ready, wb0_ready, rd_ready}); end
        tick(); idle_inputs();
        @(negedge clk);
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL mid_done_late: got %b expected 0", rd_done); end
        tick(); tick();
    endtask

    task automatic test_random();
        int          ref_last;
        logic [31:0] regs [16];
        bit          known [16];
        bit          v [3];
        int          g;
        bit          e_we, e_err;
        logic [4:0]  e_addr;
        logic [31:0] e_data, e_instr;
        bit          p1_v, p1_k, p2_v, p2_k;
        logic [31:0] p1_d1, p1_d2, p2_d1, p2_d2;
        int          rs, rt;
        do_reset();
        ref_last = 2;
        for (int i = 0; i < 16; i++) known[i] = 0;
        for (int c = 0; c < 3; c++) v[c] = 0;
        e_we = 0; e_err = 0; e_addr = 0; e_data = 0; e_instr = 0;
        p1_v = 0; p1_k = 0; p2_v = 0; p2_k = 0;
        p1_d1 = 0; p1_d2 = 0; p2_d1 = 0; p2_d2 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            g = -1;
            for (int k = 1; k <= 3; k++)
                if (g < 0 && v[(ref_last + k) % 3]) g = (ref_last + k) % 3;
            checks++; if ({wb1_ready, wb0_ready, rd_ready} !== ((g >= 0) ? 3'(1 << g) : 3'b000)) begin errors++; $display("FAIL rnd_grant@%0d: got %b expected grant %0d", cyc, {wb1_ready, wb0_ready, rd_ready}, g); end
            checks++; if (rf_we !== e_we || (e_we && (rf_addr3 !== e_addr || rf_data_in !== e_data))) begin errors++; $display("FAIL rnd_write@%0d: we=%b addr=%h data=%h expected %b/%h/%h", cyc, rf_we, rf_addr3, rf_data_in, e_we, e_addr, e_data); end
            checks++; if (rf_instruction !== e_instr || wb_err !== e_err) begin errors++; $display("FAIL rnd_instr@%0d: instr=%h err=%b expected %h/%b", cyc, rf_instruction, wb_err, e_instr, e_err); end
            checks++; if (rd_done !== p2_v) begin errors++; $display("FAIL rnd_done@%0d: got %b expected %b", cyc, rd_done, p2_v); end
            if (p2_v && p2_k) begin
                checks++; if (dout1 !== p2_d1 || dout2 !== p2_d2) begin errors++; $display("FAIL rnd_data@%0d: got %h %h expected %h %h", cyc, dout1, dout2, p2_d1, p2_d2); end
            end
            p2_v = p1_v; p2_k = p1_k; p2_d1 = p1_d1; p2_d2 = p1_d2;
            p1_v = 0; e_we = 0; e_err = 0;
            if (g == 0) begin
                rs = int'(rd_instr[24:21]); rt = int'(rd_instr[19:16]);
                p1_v = 1; p1_k = known[rs] && known[rt];
                p1_d1 = regs[rs]; p1_d2 = regs[rt];
                e_instr = rd_instr;
            end else if (g > 0) begin
                e_addr = (g == 1) ? wb0_addr : wb1_addr;
                e_data = (g == 1) ? wb0_data : wb1_data;
                if (e_addr < 5'd16) begin
                    e_we = 1; regs[e_addr[3:0]] = e_data; known[e_addr[3:0]] = 1;
                end else e_err = 1;
            end
            if (g >= 0) ref_last = g;
            tick();
            for (int c = 0; c < 3; c++) begin
                if (c == g || !v[c]) begin
                    v[c] = ($urandom_range(0, 3) != 0);
                    if (c == 0) rd_instr = $urandom;
                    if (c == 1) begin wb0_addr = 5'($urandom_range(0, 19)); wb0_data = $urandom; end
                    if (c == 2) begin wb1_addr = 5'($urandom_range(0, 19)); wb1_data = $urandom; end
                end
            end
            rd_valid = v[0]; wb0_valid = v[1]; wb1_valid = v[2];
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_read_basic();
        test_write_then_read();
        test_round_robin();
        test_bad_addr();
        test_same_addr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
